// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the logic it supervises.
// master: the sequencer; slave: the PLL/SDRAM side that feeds it and consumes its resets.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       sdram_ready;
  logic       sdram_reset;
  logic       sys_reset;
  logic       ce_phi;
  logic       ce_half;
  logic       timeout_err;
  logic [1:0] state;

  modport master (
    input  pll_locked, sdram_ready,
    output sdram_reset, sys_reset, ce_phi, ce_half, timeout_err, state
  );

  modport slave (
    output pll_locked, sdram_ready,
    input  sdram_reset, sys_reset, ce_phi, ce_half, timeout_err, state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Ordered reset release (SDRAM, then core) gated by a stable PLL lock, plus ce_phi/ce_half enables.
// Optional SDRAM-ready timeout/retry is built only when SEQ_TIMEOUT_EN is defined.
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES    = 1024,
  parameter int CE_DIV         = 64,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RETRY_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK  = 2'd0,
    ST_SDRAM_INIT = 2'd1,
    ST_RUN        = 2'd2,
    ST_RETRY      = 2'd3
  } state_e;

  localparam int LOCK_W = $clog2(LOCK_CYCLES);
  localparam int DIV_W  = $clog2(CE_DIV);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CE_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CE_DIV / 2 - 1);

  if (LOCK_CYCLES < 2) begin : g_bad_lock
    $error("LOCK_CYCLES must be at least 2");
  end
  if (CE_DIV < 4 || (CE_DIV % 2) != 0) begin : g_bad_div
    $error("CE_DIV must be even and at least 4");
  end
  if (TIMEOUT_CYCLES < 2 || RETRY_CYCLES < 1) begin : g_bad_timer
    $error("TIMEOUT_CYCLES must be >= 2 and RETRY_CYCLES >= 1");
  end

  logic              r_sync_meta;
  logic              r_lock_s;
  state_e            r_state;
  state_e            w_state_next;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  w_div_next;
  logic              r_sdram_reset;
  logic              r_sys_reset;
  logic              r_ce_phi;
  logic              r_ce_half;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_sync_meta <= bus.pll_locked;
      r_lock_s    <= r_sync_meta;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TMR_MAX = (TIMEOUT_CYCLES > RETRY_CYCLES) ? TIMEOUT_CYCLES : RETRY_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RETRY_LAST = TMR_W'(RETRY_CYCLES - 1);

  logic [TMR_W-1:0] r_tmr;
  logic             r_timeout_err;
  logic             w_timeout_set;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_LOCK:  if (r_lock_s && r_lock_cnt == LOCK_LAST) w_state_next = ST_SDRAM_INIT;
      ST_SDRAM_INIT: begin
        if (bus.sdram_ready) begin
          w_state_next = ST_RUN;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (r_tmr == TO_LAST) begin
          w_state_next = ST_RETRY;
        end
`endif
      end
      ST_RUN:        w_state_next = ST_RUN;
`ifdef SEQ_TIMEOUT_EN
      ST_RETRY:      if (r_tmr == RETRY_LAST) w_state_next = ST_SDRAM_INIT;
`else
      ST_RETRY:      w_state_next = ST_SDRAM_INIT;
`endif
      default:       w_state_next = ST_WAIT_LOCK;
    endcase
    // Lock loss overrides every other transition.
    if (!r_lock_s) w_state_next = ST_WAIT_LOCK;
  end

  always_comb begin
    w_div_next = '0;
    if (w_state_next == ST_RUN && r_state == ST_RUN) begin
      w_div_next = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_WAIT_LOCK;
      r_lock_cnt    <= '0;
      r_div_cnt     <= '0;
      r_sdram_reset <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_ce_phi      <= 1'b0;
      r_ce_half     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      // Counting restarts on any lock drop and on every re-entry to WAIT_LOCK.
      r_lock_cnt    <= (r_state == ST_WAIT_LOCK && w_state_next == ST_WAIT_LOCK && r_lock_s)
                       ? r_lock_cnt + 1'b1 : '0;
      r_div_cnt     <= w_div_next;
      r_sdram_reset <= !(w_state_next == ST_SDRAM_INIT || w_state_next == ST_RUN);
      r_sys_reset   <= (w_state_next != ST_RUN);
      r_ce_phi      <= (w_state_next == ST_RUN) && (w_div_next == DIV_LAST);
      r_ce_half     <= (w_state_next == ST_RUN) && (w_div_next == DIV_HALF);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Shared timer: SDRAM-ready timeout in SDRAM_INIT, re-pulse length in RETRY.
  assign w_timeout_set = (r_state == ST_SDRAM_INIT) && (w_state_next == ST_RETRY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_state_next != r_state) begin
        r_tmr <= '0;
      end else if (r_state == ST_SDRAM_INIT || r_state == ST_RETRY) begin
        r_tmr <= r_tmr + 1'b1;
      end else begin
        r_tmr <= '0;
      end
      if (w_timeout_set) r_timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.state       = r_state;
  assign bus.sdram_reset = r_sdram_reset;
  assign bus.sys_reset   = r_sys_reset;
  assign bus.ce_phi      = r_ce_phi;
  assign bus.ce_half     = r_ce_half;

endmodule
